// File: rtl/morph_frame_ctrl.sv
// morph_frame_ctrl: frame timing, config sequencing and status for two cascaded 3x3 morphology stages.
// Define MORPH_CTRL_BORDER_EN to build the LAT-delayed border mask; otherwise border_o is tied low.
module morph_frame_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int LAT   = 4
) (
  input  logic                       sclk,
  input  logic                       s_rst_n,
  input  logic                       vsync_i,
  input  logic                       hsync_i,
  input  logic                       data_en_i,
  input  logic                       cfg_valid_i,
  input  logic [1:0]                 cfg_mode_i,
  output logic                       cfg_ready_o,
  output logic [1:0]                 stage0_op_o,
  output logic [1:0]                 stage1_op_o,
  output logic [$clog2(IMG_W)-1:0]   col_cnt_o,
  output logic [$clog2(IMG_H)-1:0]   row_cnt_o,
  output logic                       frame_busy_o,
  output logic                       frame_done_o,
  output logic [1:0]                 err_o,
  output logic                       border_o
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t     state;
  logic       vs_r, de_r, pending, line_full;
  logic [1:0] shadow;
  logic       fs, le, accept, col_last, row_last;
  logic       unused_ok;
  assign fs           = vs_r & ~vsync_i;
  assign le           = de_r & ~data_en_i;
  assign accept       = cfg_valid_i & ~pending;
  assign col_last     = col_cnt_o == CW'(IMG_W - 1);
  assign row_last     = row_cnt_o == RW'(IMG_H - 1);
  assign cfg_ready_o  = ~pending;
  assign frame_busy_o = state == ACTIVE;
  assign frame_done_o = state == DONE;
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      vs_r        <= 1'b0;
      de_r        <= 1'b0;
      pending     <= 1'b0;
      shadow      <= 2'd0;
      stage0_op_o <= 2'b00;
      stage1_op_o <= 2'b00;
      state       <= IDLE;
      col_cnt_o   <= '0;
      row_cnt_o   <= '0;
      line_full   <= 1'b0;
      err_o       <= 2'b00;
    end else begin
      vs_r <= vsync_i;
      de_r <= data_en_i;
      if (accept) begin
        shadow  <= cfg_mode_i;
        pending <= 1'b1;
      end else if (fs && pending) begin
        pending     <= 1'b0;
        stage0_op_o <= (shadow == 2'd2) ? 2'b10 : {1'b0, shadow[0]};
        stage1_op_o <= {&shadow, 1'b0};
      end
      if (fs) begin
        state     <= ACTIVE;
        col_cnt_o <= '0;
        row_cnt_o <= '0;
        line_full <= 1'b0;
        err_o     <= {state == ACTIVE, 1'b0};
      end else begin
        if (data_en_i && state != ACTIVE) err_o[0] <= 1'b1;
        if (state == DONE) state <= IDLE;
        if (state == ACTIVE) begin
          if (data_en_i) begin
            // line_full marks that the last column has already been consumed
            if (col_last) begin
              line_full <= 1'b1;
              if (line_full) err_o[0] <= 1'b1;
            end else col_cnt_o <= col_cnt_o + 1'b1;
          end else if (le) begin
            col_cnt_o <= '0;
            line_full <= 1'b0;
            if (row_last) state <= DONE;
            else row_cnt_o <= row_cnt_o + 1'b1;
          end
        end
      end
    end
  end
`ifdef MORPH_CTRL_BORDER_EN
  logic [LAT-1:0] dly;
  logic           raw;
  assign raw = data_en_i & frame_busy_o & (col_cnt_o == '0 | col_last | row_cnt_o == '0 | row_last);
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) dly <= '0;
    else begin
      dly[0] <= raw;
      for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
    end
  end
  assign border_o  = dly[LAT-1];
  assign unused_ok = hsync_i;
`else
  assign border_o  = 1'b0;
  assign unused_ok = hsync_i ^ (LAT > 0);
`endif
endmodule

// File: tb/tb_morph_frame_ctrl.sv
// tb_morph_frame_ctrl: table-driven frames plus directed corner sequences for morph_frame_ctrl.
module tb_morph_frame_ctrl;
  localparam int W = 8, H = 4, LAT = 4;
  logic       sclk = 0, s_rst_n = 0, vsync_i = 1, hsync_i = 0, data_en_i = 0, cfg_valid_i = 0;
  logic [1:0] cfg_mode_i = 0;
  logic       cfg_ready_o, frame_busy_o, frame_done_o, border_o;
  logic [1:0] stage0_op_o, stage1_op_o, err_o, row_cnt_o;
  logic [2:0] col_cnt_o;
  int         n_vec = 0, n_err = 0;
  morph_frame_ctrl #(.IMG_W(W), .IMG_H(H), .LAT(LAT)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .vsync_i(vsync_i), .hsync_i(hsync_i), .data_en_i(data_en_i),
    .cfg_valid_i(cfg_valid_i), .cfg_mode_i(cfg_mode_i), .cfg_ready_o(cfg_ready_o),
    .stage0_op_o(stage0_op_o), .stage1_op_o(stage1_op_o), .col_cnt_o(col_cnt_o), .row_cnt_o(row_cnt_o),
    .frame_busy_o(frame_busy_o), .frame_done_o(frame_done_o), .err_o(err_o), .border_o(border_o)
  );
  always #5 sclk = ~sclk;
  typedef struct {
    logic vs, de, cv; logic [1:0] cm;
    logic [2:0] col; logic [1:0] row; logic busy, done; logic [1:0] err; logic rdy; logic [1:0] op0, op1;
  } vec_t;
  vec_t       tbl[$];
  logic [2:0] g_col = 0;
  logic [1:0] g_row = 0, g_op0 = 0, g_op1 = 0, g_n0 = 0, g_n1 = 0;
  logic       g_rdy = 1;
  localparam logic [15:0] RST = 16'({3'd0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0});
  function automatic logic [15:0] snap();
    return 16'({col_cnt_o, row_cnt_o, frame_busy_o, frame_done_o, err_o, cfg_ready_o, stage0_op_o, stage1_op_o, border_o});
  endfunction
  function automatic logic is_edge(input vec_t v);
    return v.de & v.busy & (v.col == 0 || v.col == 7 || v.row == 0 || v.row == 3);
  endfunction
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc(input logic vs, input logic de, input logic cv, input logic [1:0] cm);
    @(negedge sclk);
    vsync_i = vs; data_en_i = de; hsync_i = ~de; cfg_valid_i = cv; cfg_mode_i = cm;
  endtask
  task automatic push(input logic vs, input logic de, input logic cv, input logic [1:0] cm,
                      input logic [2:0] col, input logic [1:0] row, input logic busy, input logic done);
    vec_t v;
    v.vs = vs; v.de = de; v.cv = cv; v.cm = cm; v.col = col; v.row = row; v.busy = busy; v.done = done;
    v.err = 2'b00; v.rdy = g_rdy; v.op0 = g_op0; v.op1 = g_op1;
    tbl.push_back(v);
  endtask
  task automatic gen_start();
    push(1, 0, 0, 0, g_col, g_row, 0, 0);
    push(0, 0, 0, 0, g_col, g_row, 0, 0);
    g_col = 0; g_row = 0;
    if (!g_rdy) begin g_op0 = g_n0; g_op1 = g_n1; g_rdy = 1; end
    push(0, 0, 0, 0, 0, 0, 1, 0);
  endtask
  task automatic gen_frame(input int cfg_px, input logic [1:0] cm, input logic [1:0] n0, input logic [1:0] n1);
    gen_start();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        logic cv;
        cv = (r * 8 + c == cfg_px);
        push(0, 1, cv, cv ? cm : 2'd0, 3'(c), 2'(r), 1, 0);
        if (cv) begin g_rdy = 0; g_n0 = n0; g_n1 = n1; end
      end
      push(0, 0, 0, 0, 3'd7, 2'(r), 1, 0);
      if (r < 3) push(0, 0, 0, 0, 3'd0, 2'(r + 1), 1, 0);
      else begin
        push(0, 0, 0, 0, 3'd0, 2'd3, 0, 1);
        push(0, 0, 0, 0, 3'd0, 2'd3, 0, 0);
      end
    end
    g_col = 0; g_row = 3;
  endtask
  initial begin
    logic done_seen;
    logic b;
    gen_frame(-1, 2'd0, 2'b00, 2'b00);
    gen_frame(10, 2'd3, 2'b01, 2'b10);
    gen_start();
    repeat (2) @(negedge sclk);
    chk("reset", snap(), RST);
    s_rst_n = 1;
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].vs, tbl[i].de, tbl[i].cv, tbl[i].cm);
      b = 1'b0;
`ifdef MORPH_CTRL_BORDER_EN
      if (i >= LAT) b = is_edge(tbl[i-LAT]);
`endif
      chk($sformatf("vec%0d", i), snap(), 16'({tbl[i].col, tbl[i].row, tbl[i].busy, tbl[i].done, tbl[i].err,
                                               tbl[i].rdy, tbl[i].op0, tbl[i].op1, b}));
    end
    @(negedge sclk); s_rst_n = 0; #1;
    chk("rst_mid", snap(), RST);
    @(negedge sclk); s_rst_n = 1;
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("fresh", 16'({frame_busy_o, col_cnt_o, row_cnt_o, err_o, stage0_op_o, stage1_op_o}), 16'({1'b1, 3'd0, 2'd0, 2'b00, 4'd0}));
    done_seen = 0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 8; c++) begin cyc(0, 1, 0, 0); done_seen |= frame_done_o; end
      cyc(0, 0, 0, 0); done_seen |= frame_done_o;
    end
    cyc(0, 0, 0, 0);
    chk("two_lines", 16'({col_cnt_o, row_cnt_o}), 16'({3'd0, 2'd2}));
    cyc(1, 0, 0, 0); done_seen |= frame_done_o;
    cyc(0, 0, 0, 0); done_seen |= frame_done_o;
    cyc(0, 0, 0, 0); done_seen |= frame_done_o;
    chk("restart", 16'({frame_busy_o, col_cnt_o, row_cnt_o, err_o}), 16'({1'b1, 3'd0, 2'd0, 2'b10}));
    chk("no_done", 16'(done_seen), 16'd0);
    cyc(1, 0, 0, 0); cyc(0, 0, 1, 2'd2);
    chk("acc_fs_rdy", 16'({cfg_ready_o, stage0_op_o, stage1_op_o}), 16'({1'b1, 2'b00, 2'b00}));
    cyc(0, 0, 0, 0);
    chk("acc_fs_hold", 16'({cfg_ready_o, stage0_op_o, stage1_op_o}), 16'({1'b0, 2'b00, 2'b00}));
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("acc_fs_pend", 16'({cfg_ready_o, stage0_op_o, stage1_op_o}), 16'({1'b0, 2'b00, 2'b00}));
    cyc(0, 0, 0, 0);
    chk("acc_next", 16'({cfg_ready_o, stage0_op_o, stage1_op_o}), 16'({1'b1, 2'b10, 2'b00}));
    for (int p = 0; p < 10; p++) begin
      cyc(0, 1, 0, 0);
      if (p == 8) chk("sat_col", 16'({col_cnt_o, err_o[0]}), 16'({3'd7, 1'b0}));
      if (p == 9) chk("sat_ovf", 16'({col_cnt_o, err_o[0]}), 16'({3'd7, 1'b1}));
    end
    cyc(0, 0, 0, 0);
    chk("ovf_le", 16'({col_cnt_o, err_o[0]}), 16'({3'd7, 1'b1}));
    cyc(0, 0, 0, 0);
    chk("ovf_hold", 16'({col_cnt_o, row_cnt_o, err_o[0]}), 16'({3'd0, 2'd1, 1'b1}));
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("ovf_clr", 16'(err_o), 16'(2'b10));
    @(negedge sclk); s_rst_n = 0;
    @(negedge sclk); s_rst_n = 1;
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
    chk("idle_de", 16'({frame_busy_o, col_cnt_o, row_cnt_o, err_o}), 16'({1'b0, 3'd0, 2'd0, 2'b01}));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
